// File: rtl/sine_sample_sequencer.sv
// Phase-accumulator address sequencer feeding the 1024x16 sine ROM and presenting one sample per period to the DSM.
// Optional build macro AMPLITUDE_SCALE_EN inserts a gain stage (SCALE state) after CAPTURE.
module sine_sample_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int PHASE_W     = 24,
    parameter int DIV_W       = 16,
    parameter int ROM_LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic [DIV_W-1:0]   sample_div,
    input  logic [7:0]         amplitude,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [DATA_W-1:0]  rom_q,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int WCNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY + 1) : 1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

`ifdef AMPLITUDE_SCALE_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_SCALE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;
`endif

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [WCNT_W-1:0]   wait_q, wait_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                tick;

`ifdef AMPLITUDE_SCALE_EN
    logic [DATA_W-1:0]        raw_q, raw_d;
    logic [7:0]               amp_q, amp_d;
    logic [7:0]               gain;
    logic signed [DATA_W+8:0] prod;
    logic [8:0]               unused_prod;

    // Gain saturates at 128 (unity); the product is centred on mid-scale and floored by >>> 7.
    assign gain        = (amp_q >= 8'd128) ? 8'd128 : amp_q;
    assign prod        = $signed(raw_q ^ MID) * $signed({1'b0, gain});
    assign unused_prod = {prod[DATA_W+8:DATA_W+7], prod[6:0]};
`else
    logic unused_amp;
    assign unused_amp = ^amplitude;
`endif

    assign tick = enable && (div_q == sample_div);

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        phase_d  = phase_q;
        addr_d   = addr_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        div_d    = (!enable || tick) ? '0 : div_q + DIV_W'(1);
        ovr_d    = enable && (ovr_q || (tick && state_q != S_IDLE));
`ifdef AMPLITUDE_SCALE_EN
        raw_d    = raw_q;
        amp_d    = amp_q;
`endif
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                // Address is loaded on the IDLE->ISSUE edge so it is already on the ROM bus during ISSUE.
                S_IDLE: if (tick) begin
                    state_d = S_ISSUE;
                    addr_d  = phase_q[PHASE_W-1 -: ADDR_W];
                end
                S_ISSUE: begin
                    wait_d  = WCNT_W'(ROM_LATENCY - 1);
                    state_d = (ROM_LATENCY > 1) ? S_WAIT : S_CAPTURE;
                end
                S_WAIT: begin
                    wait_d = wait_q - WCNT_W'(1);
                    if (wait_q == WCNT_W'(1)) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    phase_d = phase_q + tuning_word;
`ifdef AMPLITUDE_SCALE_EN
                    raw_d   = rom_q;
                    amp_d   = amplitude;
                    state_d = S_SCALE;
                end
                S_SCALE: begin
                    sample_d = prod[DATA_W+6:7] ^ MID;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
`else
                    sample_d = rom_q;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            wait_q   <= '0;
            phase_q  <= '0;
            addr_q   <= '0;
            sample_q <= MID;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef AMPLITUDE_SCALE_EN
            raw_q    <= MID;
            amp_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            wait_q   <= wait_d;
            phase_q  <= phase_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
`ifdef AMPLITUDE_SCALE_EN
            raw_q    <= raw_d;
            amp_q    <= amp_d;
`endif
        end
    end

    assign rom_address  = addr_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_sine_sample_sequencer.sv
// Bench for sine_sample_sequencer: behavioural ROM, event-schedule reference model, vector table and directed corners.
// Honours AMPLITUDE_SCALE_EN for latency and gain expectations.
module tb_sine_sample_sequencer;
    localparam int RL = 2;
`ifdef AMPLITUDE_SCALE_EN
    localparam int LAT = RL + 3;
`else
    localparam int LAT = RL + 2;
`endif

    logic        clock = 1'b0, reset_n = 1'b1, enable = 1'b0;
    logic [23:0] tuning_word = '0;
    logic [15:0] sample_div = '0;
    logic [7:0]  amplitude = 8'd128;
    logic [9:0]  rom_address;
    logic [15:0] rom_q = '0, sample;
    logic        sample_valid, busy, overrun;

    int n_chk = 0, n_fail = 0, vcnt = 0;
    bit chk_on = 1'b0;

    always #5 clock = ~clock;

    sine_sample_sequencer dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .tuning_word(tuning_word),
        .sample_div(sample_div), .amplitude(amplitude), .rom_address(rom_address), .rom_q(rom_q),
        .sample(sample), .sample_valid(sample_valid), .busy(busy), .overrun(overrun));

    // Two-stage synchronous ROM: address seen in cycle A gives data in cycle A+2.
    logic [15:0] mem [1024];
    logic [9:0]  a1 = '0;
    always @(posedge clock) begin
        a1    <= rom_address;
        rom_q <= mem[a1];
    end

    function automatic logic [15:0] expect_sample(input logic [15:0] q, input logic [7:0] amp);
`ifdef AMPLITUDE_SCALE_EN
        int d, g, r;
        d = int'(q) - 32768;
        g = (amp >= 8'd128) ? 128 : int'(amp);
        r = (d * g) >>> 7;
        return 16'(r + 32768);
`else
        return q;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: schedule of accepted ticks, capture and valid cycles derived from the latency rules.
    int          cyc = 0, m_cnt = 0, free_at = 0, busy_from = 0, pend_cap = 0, pend_vld = 0, vld_at = -1;
    logic [23:0] m_phase = '0;
    logic [9:0]  m_addr = '0;
    logic        m_ovr = 1'b0, pend = 1'b0;
    logic [15:0] m_sample = 16'h8000, pend_samp = 16'h8000;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= 0; m_cnt <= 0; free_at <= 0; busy_from <= 0; pend_cap <= 0; pend_vld <= 0; vld_at <= -1;
            m_phase <= '0; m_addr <= '0; m_ovr <= 1'b0; pend <= 1'b0;
            m_sample <= 16'h8000; pend_samp <= 16'h8000;
        end else begin : step
            int cnt, fa, bf, pc, pv, va;
            logic [23:0] ph;
            logic [9:0]  ad;
            logic        ov, pd;
            logic [15:0] ms, ps;
            cnt = m_cnt; fa = free_at; bf = busy_from; pc = pend_cap; pv = pend_vld; va = vld_at;
            ph = m_phase; ad = m_addr; ov = m_ovr; pd = pend; ms = m_sample; ps = pend_samp;
            if (!enable) begin
                cnt = 0; ov = 1'b0; pd = 1'b0;
                if (fa > cyc + 1) fa = cyc + 1;
            end else begin
                if (pd && cyc == pc) begin
                    ph = ph + tuning_word;
                    ps = expect_sample(mem[ad], amplitude);
                end
                if (pd && cyc == pv - 1) begin
                    va = cyc + 1; ms = ps; pd = 1'b0;
                end
                if (cnt == int'(sample_div)) begin
                    cnt = 0;
                    if (cyc >= fa) begin
                        ad = ph[23:14]; pd = 1'b1;
                        pc = cyc + RL + 1; pv = cyc + LAT; bf = cyc + 1; fa = cyc + LAT;
                    end else ov = 1'b1;
                end else cnt++;
            end
            m_cnt <= cnt; free_at <= fa; busy_from <= bf; pend_cap <= pc; pend_vld <= pv; vld_at <= va;
            m_phase <= ph; m_addr <= ad; m_ovr <= ov; pend <= pd; m_sample <= ms; pend_samp <= ps;
            cyc <= cyc + 1;
        end
    end

    always @(negedge clock) begin
        if (reset_n && chk_on) begin
            check("sample_valid", sample_valid, vld_at == cyc);
            check("sample", sample, m_sample);
            check("rom_address", rom_address, m_addr);
            check("busy", busy, (cyc >= busy_from) && (cyc < free_at));
            check("overrun", overrun, m_ovr);
            if (sample_valid) vcnt++;
        end
    end

    typedef struct {
        logic [23:0] tw;
        logic [15:0] div;
        int          ncyc;
        int          exp_vld;
        logic        exp_ovr;
        logic [9:0]  exp_addr;
    } vec_t;

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        enable  = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Waits (bounded) until busy rises; reports cycles waited or -1.
    task automatic wait_busy(input int limit, output int waited);
        waited = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock); #1;
            if (busy) begin waited = i; break; end
        end
    endtask

    initial begin
        vec_t tbl[4];
        int base, w, lat;
        logic [9:0]  e_addr;
        logic [15:0] e_samp;
        bit ok;

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        tbl[1] = '{24'h00C000, 16'd9, 60, 5, 1'b0, 10'd15};
        tbl[3] = '{24'hFFC000, 16'd4, 30, 5, 1'b0, 10'd1019};
`ifdef AMPLITUDE_SCALE_EN
        tbl[0] = '{24'h004000, 16'd3, 39, 4, 1'b1, 10'd4};
        tbl[2] = '{24'h004000, 16'd1, 20, 3, 1'b1, 10'd3};
`else
        tbl[0] = '{24'h004000, 16'd3, 39, 9, 1'b0, 10'd8};
        tbl[2] = '{24'h004000, 16'd1, 20, 4, 1'b1, 10'd4};
`endif
        chk_on = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        base = vcnt;
        repeat (100) @(negedge clock);
        #1 check("idle_no_valid", vcnt - base, 0);

        foreach (tbl[i]) begin
            do_reset();
            @(negedge clock);
            tuning_word = tbl[i].tw; sample_div = tbl[i].div; enable = 1'b1;
            base = vcnt;
            repeat (tbl[i].ncyc - 1) @(negedge clock);
            #1 check($sformatf("vec%0d_overrun", i), overrun, tbl[i].exp_ovr);
            @(negedge clock);
            enable = 1'b0;
            repeat (10) @(negedge clock);
            #1 check($sformatf("vec%0d_valids", i), vcnt - base, tbl[i].exp_vld);
            check($sformatf("vec%0d_addr", i), rom_address, tbl[i].exp_addr);
        end

        // Full table sweep at the minimum period; the 1025th sample must come from address 0 again.
        do_reset();
        @(negedge clock);
        tuning_word = 24'h004000; sample_div = 16'(LAT - 1); enable = 1'b1;
        base = vcnt; ok = 1'b0;
        for (int i = 0; i < 1025 * LAT + 50; i++) begin
            @(negedge clock); #1;
            if (vcnt - base >= 1025) begin ok = 1'b1; break; end
        end
        check("sweep_done", ok, 1'b1);
        check("sweep_wrap_addr", rom_address, 10'd0);
        check("sweep_wrap_sample", sample, expect_sample(mem[0], amplitude));

        // Latency from tick to sample_valid, then abort in WAIT.
        @(negedge clock); enable = 1'b0;
        @(negedge clock); sample_div = 16'd7; enable = 1'b1;
        wait_busy(40, w);
        check("lat_busy_seen", w >= 0, 1'b1);
        lat = -1;
        for (int i = 1; i < 20; i++) begin
            @(negedge clock); #1;
            if (sample_valid) begin lat = i; break; end
        end
        check("tick_to_valid", lat + 1, LAT);
        wait_busy(40, w);
        check("abort_busy_seen", w >= 0, 1'b1);
        e_addr = m_addr; e_samp = m_sample;
        @(negedge clock); enable = 1'b0;
        @(negedge clock); #1;
        check("abort_busy_low", busy, 1'b0);
        base = vcnt;
        repeat (6) @(negedge clock);
        #1 check("abort_no_valid", vcnt - base, 0);
        check("abort_sample_kept", sample, e_samp);
        enable = 1'b1;
        wait_busy(40, w);
        check("resume_addr", rom_address, e_addr);

`ifdef AMPLITUDE_SCALE_EN
        begin
            logic [7:0]  amps [3];
            logic [15:0] exps [3];
            amps = '{8'd64, 8'd0, 8'd200};
            exps = '{16'hBFFF, 16'h8000, 16'hFFFF};
            for (int k = 0; k < 3; k++) begin
                do_reset();
                mem[0] = 16'hFFFF; amplitude = amps[k];
                @(negedge clock); sample_div = 16'd20; enable = 1'b1;
                for (int i = 0; i < 60; i++) begin
                    @(negedge clock); #1;
                    if (sample_valid) break;
                end
                check($sformatf("scale_amp%0d", amps[k]), sample, exps[k]);
            end
            amplitude = 8'd128;
        end
`endif

        // Randomised runs: parameters change only across an enable-low cycle; tuning word also live.
        for (int it = 0; it < 250; it++) begin
            @(negedge clock);
            enable = 1'b0;
            @(negedge clock);
            tuning_word = 24'($urandom);
            sample_div  = 16'($urandom_range(0, 12));
            amplitude   = 8'($urandom);
            enable      = 1'b1;
            repeat ($urandom_range(3, 50)) begin
                @(negedge clock);
                if ($urandom_range(0, 9) == 0) tuning_word = 24'($urandom);
            end
        end

        // Asynchronous reset mid-run with overrun set.
        @(negedge clock); enable = 1'b0;
        @(negedge clock); sample_div = 16'd1; tuning_word = 24'h00C000; enable = 1'b1;
        repeat (12) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sample", sample, 16'h8000);
        check("arst_valid", sample_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_overrun", overrun, 1'b0);
        check("arst_addr", rom_address, 10'd0);
        enable = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        base = vcnt;
        repeat (100) @(negedge clock);
        #1 check("post_reset_no_valid", vcnt - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sine_sample_sequencer.md
Name: sine_sample_sequencer

Overview:
Upstream address generator for the 1024x16 sine ROM (rom_addr16bit) in the DSM DAC toplevel. A phase accumulator advances once per sample period. The block drives the ROM address, waits out the ROM read latency, and captures rom_q. It then presents one 16-bit offset-binary sample per period, with a one-cycle valid strobe, to the downstream delta-sigma modulator.

Parameters:
ADDR_W, 10, ROM address width; addresses phase[PHASE_W-1 -: ADDR_W]
DATA_W, 16, ROM word and sample width
PHASE_W, 24, phase accumulator and tuning word width
DIV_W, 16, sample-period divider width
ROM_LATENCY, 2, clocks from the first cycle a new rom_address is visible to rom_q being valid

Ports:
clock  in  1  system clock; everything is sampled on the rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  run/stop
tuning_word  in  PHASE_W  phase increment per sample
sample_div  in  DIV_W  sample period = sample_div+1 clocks
amplitude  in  8  gain; used only with AMPLITUDE_SCALE_EN, otherwise ignored
rom_address  out  ADDR_W  to rom_addr16bit.address
rom_q  in  DATA_W  from rom_addr16bit.q
sample  out  DATA_W  held sample for the DSM
sample_valid  out  1  one-cycle pulse when sample updates
busy  out  1  high whenever the FSM is not in IDLE
overrun  out  1  sticky: a tick was dropped because the FSM was busy

Behaviour:
- Reset values (asynchronous):
  - phase = 0, div counter = 0, rom_address = 0
  - sample = 16'h8000 (mid-scale), sample_valid = 0, busy = 0, overrun = 0
  - FSM = IDLE
- Divider:
  - When enable=1, the counter counts 0..sample_div and then wraps.
  - tick = (counter == sample_div). sample_div=0 gives a tick every clock.
  - When enable=0, the counter is held at 0 and no ticks occur.
- FSM states are IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE: on tick, go to ISSUE.
  - ISSUE: register rom_address <= phase[PHASE_W-1 -: ADDR_W], load the wait counter with ROM_LATENCY-1, go to WAIT.
  - WAIT: decrement each clock; at 0, go to CAPTURE.
  - CAPTURE: sample <= rom_q, sample_valid=1 for exactly this one cycle, phase <= phase + tuning_word (mod 2^PHASE_W, no saturation), go to IDLE.
- Latency:
  - With tick in cycle T, rom_address shows the new value from cycle T+1 (cycle A).
  - rom_q is captured at the end of cycle A+ROM_LATENCY.
  - sample_valid is high in cycle T+ROM_LATENCY+2. With the default ROM_LATENCY, that is T+4.
- rom_address is held stable from ISSUE until the next ISSUE and never changes during WAIT.
- Minimum sustainable period is ROM_LATENCY+2 clocks.
  - A tick arriving while the FSM is not in IDLE is dropped and sets overrun.
  - A tick and a return to IDLE in the same cycle also count as a drop.
- overrun clears only on reset_n or while enable=0.
- enable deasserted mid-operation:
  - The FSM returns to IDLE on the next edge with no sample_valid.
  - phase, sample and rom_address keep their values.
- Phase wrap:
  - The address wraps from 1023 to 0 seamlessly.
  - The phase is cleared only by reset_n.
- tuning_word, sample_div and amplitude are sampled live. A change takes effect at the next ISSUE, divider compare or CAPTURE respectively.

Optional Feature:
AMPLITUDE_SCALE_EN
- Defined:
  - Adds a SCALE state between CAPTURE and IDLE.
  - sample = (((rom_q - 0x8000) signed * min(amplitude,128)) >>> 7) + 0x8000.
  - amplitude 128 or above is unity; amplitude 0 gives 0x8000.
  - sample_valid moves to cycle T+ROM_LATENCY+3, and the minimum period becomes ROM_LATENCY+3.
- Undefined: the amplitude port exists but is unused, and the latency is as above.

Test Plan:
1. Reset check: assert reset_n=0 mid-run with clock running. Outputs go to their reset values immediately, asynchronously, without waiting for a clock edge. After release with enable=0, no sample_valid occurs for 100 clocks.
2. Full-table sweep: ROM preloaded from mem_sine_01.txt, tuning_word=24'h004000, sample_div=49, enable=1.
   - rom_address steps 0,1,2,... once per 50 clocks.
   - sample_valid fires 4 clocks after each tick, and sample equals ROM[addr].
   - After 1024 samples the address wraps to 0.
3. Frequency step: tuning_word=24'h00C000. The address sequence is 0,3,6,...,1020,1023,2 (mod 1024). No extra or missing valids.
4. Overrun: sample_div=1 (period 2, below the minimum of 4). overrun=1 after the second tick and the valid spacing is ≥4 clocks. Pulsing enable low clears overrun.
5. Abort: drop enable while in WAIT. There is no sample_valid, busy falls the next cycle, and sample keeps its old value. On re-enable, the next address continues from the retained phase.
6. AMPLITUDE_SCALE_EN build:
   - amplitude=64 with rom_q=16'hFFFF gives sample 16'hBFFF.
   - amplitude=0 gives 16'h8000.
   - amplitude=200 gives sample equal to rom_q.
   - sample_valid arrives at T+5.
